// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C APB sequencer.
// Holds the register map of the I2C master block, the cmd enable and status
// bit positions, and the state encodings of the sequencer and the APB engine.
package i2c_pkg;

    localparam logic [7:0] REG_PRESCALER = 8'h00;
    localparam logic [7:0] REG_CMD       = 8'h01;
    localparam logic [7:0] REG_TRANSMIT  = 8'h02;
    localparam logic [7:0] REG_RECEIVE   = 8'h03;
    localparam logic [7:0] REG_ADDR_RW   = 8'h04;
    localparam logic [7:0] REG_STATUS    = 8'h05;

    localparam int unsigned CMD_EN_BIT   = 6;
    localparam int unsigned STAT_TXFULL  = 0;
    localparam int unsigned STAT_RXEMPTY = 1;

    typedef enum logic [3:0] {
        StIdle,
        StWPre,
        StWAddr,
        StWCmd,
        StPollTx,
        StWaitWd,
        StPush,
        StPollRx,
        StPop,
        StPollDone,
        StAbort,
        StDone
    } seq_state_e;

    typedef enum logic [1:0] {
        XfIdle,
        XfSetup,
        XfAccess
    } xfer_state_e;

endpackage

// File: rtl/i2c_apb_xfer.sv
// Single-transfer APB master engine.
// i_start (while idle) latches write/addr/wdata and runs one SETUP + ACCESS
// transfer, holding ACCESS until i_pready. o_done pulses the cycle after the
// completing ACCESS, with o_rdata holding the sampled read data. psel/penable
// are low in the o_done cycle, which guarantees an idle gap between transfers.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_write, i_addr, i_wdata,
//        o_busy, o_done, o_rdata, APB o_psel/o_penable/o_pwrite/o_paddr/
//        o_pwdata, i_prdata, i_pready.
module i2c_apb_xfer
    import i2c_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_write,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_psel,
    output logic       o_penable,
    output logic       o_pwrite,
    output logic [7:0] o_paddr,
    output logic [7:0] o_pwdata,
    input  logic [7:0] i_prdata,
    input  logic       i_pready
);

    xfer_state_e r_state;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [7:0]  r_paddr;
    logic [7:0]  r_pwdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= XfIdle;
            r_done    <= 1'b0;
            r_rdata   <= 8'h00;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 8'h00;
            r_pwdata  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                XfIdle: begin
                    if (i_start) begin
                        r_psel   <= 1'b1;
                        r_pwrite <= i_write;
                        r_paddr  <= i_addr;
                        r_pwdata <= i_wdata;
                        r_state  <= XfSetup;
                    end
                end
                XfSetup: begin
                    r_penable <= 1'b1;
                    r_state   <= XfAccess;
                end
                XfAccess: begin
                    if (i_pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rdata   <= i_prdata;
                        r_done    <= 1'b1;
                        r_state   <= XfIdle;
                    end
                end
                default: r_state <= XfIdle;
            endcase
        end
    end

    assign o_busy    = (r_state != XfIdle);
    assign o_done    = r_done;
    assign o_rdata   = r_rdata;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/i2c_apb_seq_ctrl.sv
// APB master sequencer for the I2C master register block.
// Each accepted host request runs one full I2C transaction: program prescaler,
// address/rw and cmd, stream bytes through transmit/receive by polling status,
// then poll cmd until the enable bit clears. A poll that stays "not yet" for
// TIMEOUT consecutive reads aborts by clearing cmd and reporting err_o.
// Ports: pclk_i, preset_i (sync, active-high); host request req_*; write data
//        wr_data_i/wr_valid_i/wr_ready_o; read data rd_data_o/rd_valid_o;
//        done_o/err_o; APB master psel/penable/pwrite/paddr/pwdata/prdata/pready.
module i2c_apb_seq_ctrl
    import i2c_pkg::*;
#(
    parameter logic [7:0]  PRESCALE         = 8'h04,
    parameter logic [7:0]  CMD_GO           = 8'h44,
    parameter int unsigned STAT_TXFULL_BIT  = STAT_TXFULL,
    parameter int unsigned STAT_RXEMPTY_BIT = STAT_RXEMPTY,
    parameter logic [15:0] TIMEOUT          = 16'd1000
) (
    input  logic       pclk_i,
    input  logic       preset_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_len_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    output logic [7:0] rd_data_o,
    output logic       rd_valid_o,
    output logic       done_o,
    output logic       err_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic       pwrite_o,
    output logic [7:0] paddr_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i
);

    seq_state_e  r_state;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [15:0] r_poll;
    logic [7:0]  r_wbyte;
    logic        r_start;
    logic        r_wr_ready;
    logic        r_err;

    logic        w_xbusy;
    logic        w_xdone;
    logic [7:0]  w_xrdata;
    logic        w_xwrite;
    logic [7:0]  w_xaddr;
    logic [7:0]  w_xwdata;
    logic [15:0] w_poll_inc;
    logic        w_timeout;
    logic [7:0]  w_cnt_inc;

    assign w_poll_inc = (r_poll == 16'hFFFF) ? r_poll : r_poll + 16'd1;
    assign w_timeout  = (w_poll_inc >= TIMEOUT);
    assign w_cnt_inc  = r_cnt + 8'd1;

    // The APB command is a pure function of the state that issued the start.
    always_comb begin
        w_xwrite = 1'b0;
        w_xaddr  = REG_STATUS;
        w_xwdata = 8'h00;
        case (r_state)
            StWPre:     begin w_xwrite = 1'b1; w_xaddr = REG_PRESCALER; w_xwdata = PRESCALE; end
            StWAddr:    begin w_xwrite = 1'b1; w_xaddr = REG_ADDR_RW; w_xwdata = {r_addr, r_rw}; end
            StWCmd:     begin w_xwrite = 1'b1; w_xaddr = REG_CMD; w_xwdata = CMD_GO; end
            StPush:     begin w_xwrite = 1'b1; w_xaddr = REG_TRANSMIT; w_xwdata = r_wbyte; end
            StPop:      w_xaddr = REG_RECEIVE;
            StPollDone: w_xaddr = REG_CMD;
            StAbort:    begin w_xwrite = 1'b1; w_xaddr = REG_CMD; w_xwdata = 8'h00; end
            default:    w_xaddr = REG_STATUS;
        endcase
    end

    i2c_apb_xfer u_xfer (
        .i_clk     (pclk_i),
        .i_rst     (preset_i),
        .i_start   (r_start & ~w_xbusy),
        .i_write   (w_xwrite),
        .i_addr    (w_xaddr),
        .i_wdata   (w_xwdata),
        .o_busy    (w_xbusy),
        .o_done    (w_xdone),
        .o_rdata   (w_xrdata),
        .o_psel    (psel_o),
        .o_penable (penable_o),
        .o_pwrite  (pwrite_o),
        .o_paddr   (paddr_o),
        .o_pwdata  (pwdata_o),
        .i_prdata  (prdata_i),
        .i_pready  (pready_i)
    );

    // Every transition into an APB state raises r_start for one cycle.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            r_state    <= StIdle;
            r_rw       <= 1'b0;
            r_addr     <= 7'h00;
            r_len      <= 8'h00;
            r_cnt      <= 8'h00;
            r_poll     <= 16'h0000;
            r_wbyte    <= 8'h00;
            r_start    <= 1'b0;
            r_wr_ready <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_wr_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_rw    <= req_rw_i;
                        r_addr  <= req_addr_i;
                        r_len   <= req_len_i;
                        r_cnt   <= 8'h00;
                        r_poll  <= 16'h0000;
                        r_err   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= StWPre;
                    end
                end
                StWPre: if (w_xdone) begin r_start <= 1'b1; r_state <= StWAddr; end
                StWAddr: if (w_xdone) begin r_start <= 1'b1; r_state <= StWCmd; end
                StWCmd: begin
                    if (w_xdone) begin
                        r_start <= 1'b1;
                        if (r_len == 8'h00) r_state <= StPollDone;
                        else if (r_rw)      r_state <= StPollRx;
                        else                r_state <= StPollTx;
                    end
                end
                StPollTx: begin
                    if (w_xdone) begin
                        if (w_xrdata[STAT_TXFULL_BIT]) begin
                            r_poll  <= w_poll_inc;
                            r_start <= 1'b1;
                            if (w_timeout) r_state <= StAbort;
                        end else begin
                            r_poll  <= 16'h0000;
                            r_state <= StWaitWd;
                        end
                    end
                end
                StWaitWd: begin
                    if (wr_valid_i) begin
                        r_wbyte    <= wr_data_i;
                        r_wr_ready <= 1'b1;
                        r_start    <= 1'b1;
                        r_state    <= StPush;
                    end
                end
                StPush: begin
                    if (w_xdone) begin
                        r_cnt   <= w_cnt_inc;
                        r_start <= 1'b1;
                        r_state <= (w_cnt_inc == r_len) ? StPollDone : StPollTx;
                    end
                end
                StPollRx: begin
                    if (w_xdone) begin
                        r_start <= 1'b1;
                        if (w_xrdata[STAT_RXEMPTY_BIT]) begin
                            r_poll <= w_poll_inc;
                            if (w_timeout) r_state <= StAbort;
                        end else begin
                            r_poll  <= 16'h0000;
                            r_state <= StPop;
                        end
                    end
                end
                StPop: begin
                    if (w_xdone) begin
                        r_cnt   <= w_cnt_inc;
                        r_start <= 1'b1;
                        r_state <= (w_cnt_inc == r_len) ? StPollDone : StPollRx;
                    end
                end
                StPollDone: begin
                    if (w_xdone) begin
                        if (w_xrdata[CMD_EN_BIT]) begin
                            r_poll  <= w_poll_inc;
                            r_start <= 1'b1;
                            if (w_timeout) r_state <= StAbort;
                        end else begin
                            r_poll  <= 16'h0000;
                            r_state <= StDone;
                        end
                    end
                end
                StAbort: if (w_xdone) begin r_err <= 1'b1; r_state <= StDone; end
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (r_state == StIdle);
    assign done_o      = (r_state == StDone);
    assign err_o       = (r_state == StDone) & r_err;
    assign wr_ready_o  = r_wr_ready;
    // The engine's done pulse lands on the cycle after ACCESS, with data held.
    assign rd_valid_o  = (r_state == StPop) & w_xdone;
    assign rd_data_o   = w_xrdata;

endmodule

// File: tb/tb_i2c_apb_seq_ctrl.sv
// Self-checking bench for i2c_apb_seq_ctrl: an APB slave model of the I2C
// register block, a host write-data source, a bus monitor, and a transaction
// model that predicts the full APB access list from the register-level rules.
module tb_i2c_apb_seq_ctrl;

    localparam int TO = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, done, err;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready;

    always #5 clk = ~clk;

    i2c_apb_seq_ctrl #(.TIMEOUT(TO[15:0])) dut (
        .pclk_i      (clk),
        .preset_i    (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_rw_i    (req_rw),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .wr_data_i   (wr_data),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .done_o      (done),
        .err_o       (err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready)
    );

    // Slave configuration for the current transaction.
    bit         s_rw;
    int         s_busy_n, s_cmd_busy_n, s_ws;
    bit         s_clr;
    logic [7:0] rx_mem [0:255];
    logic [7:0] wmem   [0:255];
    int         wlen;

    int         stat_cnt, cmd_cnt, ws_cnt;
    logic [7:0] rx_idx;
    logic [7:0] junk;
    logic [7:0] rd_val;

    assign pready = (ws_cnt >= s_ws);
    assign prdata = pready ? rd_val : junk;

    always_comb begin
        rd_val = 8'h00;
        case (paddr)
            8'h05: begin
                if (stat_cnt < s_busy_n) rd_val = s_rw ? 8'h02 : 8'h03;
                else                     rd_val = s_rw ? 8'h00 : 8'h02;
            end
            8'h01:   rd_val = (cmd_cnt < s_cmd_busy_n) ? 8'h44 : 8'h04;
            8'h03:   rd_val = rx_mem[rx_idx];
            default: rd_val = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (s_clr) begin
            stat_cnt <= 0;
            cmd_cnt  <= 0;
            ws_cnt   <= 0;
            rx_idx   <= 8'h00;
        end else if (psel && penable) begin
            if (!pready) ws_cnt <= ws_cnt + 1;
            else begin
                ws_cnt <= 0;
                if (!pwrite && paddr == 8'h05) stat_cnt <= (stat_cnt < s_busy_n) ? stat_cnt + 1 : 0;
                if (!pwrite && paddr == 8'h01) cmd_cnt <= cmd_cnt + 1;
                if (!pwrite && paddr == 8'h03) rx_idx <= rx_idx + 8'd1;
            end
        end
    end

    // Monitor: APB access log, protocol violations, host-side pulses.
    logic [16:0] log_q [$];
    logic [7:0]  rd_q  [$];
    int          wr_pulses, done_cnt, err_cnt, prot;
    logic        p_psel, p_penable, p_pwrite, p_cmpl, p_done;
    logic [7:0]  p_addr, p_wdata;

    initial begin
        p_psel = 0; p_penable = 0; p_pwrite = 0; p_cmpl = 0; p_done = 0;
        p_addr = 0; p_wdata = 0;
        wr_pulses = 0; done_cnt = 0; err_cnt = 0; prot = 0;
        forever begin
            @(negedge clk);
            if (s_clr) begin
                log_q.delete(); rd_q.delete();
                wr_pulses = 0; done_cnt = 0; err_cnt = 0; prot = 0;
            end else begin
                if (penable && !psel) prot++;
                if (psel && penable && !p_psel) prot++;
                if (psel && p_psel && !p_cmpl &&
                    (paddr != p_addr || pwrite != p_pwrite || pwdata != p_wdata)) prot++;
                if (p_psel && !p_penable && !(psel && penable)) prot++;
                if (psel && !penable && p_psel && p_penable && !p_cmpl) prot++;
                if (p_cmpl && psel) prot++;
                if (err && !done) prot++;
                if (p_done && !req_ready && !rst) prot++;
                if (psel && penable && pready) log_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
                if (wr_ready) wr_pulses++;
                if (rd_valid) rd_q.push_back(rd_data);
                if (done) done_cnt++;
                if (done && err) err_cnt++;
            end
            p_cmpl = psel && penable && pready;
            p_psel = psel; p_penable = penable; p_pwrite = pwrite;
            p_addr = paddr; p_wdata = pwdata; p_done = done;
        end
    end

    // Host write-data source with random gaps after each consumed byte.
    initial begin
        int wr_idx, gap;
        wr_idx = 0; gap = 0; wr_valid = 0; wr_data = 0;
        forever begin
            @(negedge clk);
            if (s_clr) begin
                wr_idx = 0; gap = 0;
            end else begin
                if (wr_ready) begin wr_idx++; gap = $urandom_range(0, 2); end
                else if (gap > 0) gap--;
            end
            wr_valid = (gap == 0) && (wr_idx < wlen);
            wr_data  = wmem[wr_idx[7:0]];
        end
    end

    int          n_vec = 0, n_err = 0;
    logic [16:0] exp_log [$];
    logic [7:0]  exp_rd  [$];
    int          exp_wr;
    bit          exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the ordered APB accesses one transaction must produce.
    task automatic build_exp(input bit rw, input logic [6:0] addr, input int len,
                             input int busy_n, input int cmd_busy);
        bit ab;
        exp_log.delete(); exp_rd.delete(); exp_wr = 0; ab = 0;
        exp_log.push_back({1'b1, 8'h00, 8'h04});
        exp_log.push_back({1'b1, 8'h04, addr, rw});
        exp_log.push_back({1'b1, 8'h01, 8'h44});
        for (int i = 0; i < len && !ab; i++) begin
            int n;
            n = (busy_n >= TO) ? TO : busy_n;
            for (int k = 0; k < n; k++) exp_log.push_back({1'b0, 8'h05, rw ? 8'h02 : 8'h03});
            if (busy_n >= TO) ab = 1;
            else begin
                exp_log.push_back({1'b0, 8'h05, rw ? 8'h00 : 8'h02});
                if (rw) begin
                    exp_log.push_back({1'b0, 8'h03, rx_mem[i]});
                    exp_rd.push_back(rx_mem[i]);
                end else begin
                    exp_log.push_back({1'b1, 8'h02, wmem[i]});
                    exp_wr++;
                end
            end
        end
        if (!ab) begin
            int n;
            n = (cmd_busy >= TO) ? TO : cmd_busy;
            for (int k = 0; k < n; k++) exp_log.push_back({1'b0, 8'h01, 8'h44});
            if (cmd_busy >= TO) ab = 1;
            else exp_log.push_back({1'b0, 8'h01, 8'h04});
        end
        if (ab) exp_log.push_back({1'b1, 8'h01, 8'h00});
        exp_err = ab;
    endtask

    task automatic setup_txn(input bit rw, input int len, input int busy_n,
                             input int cmd_busy, input int ws);
        s_rw = rw; s_busy_n = busy_n; s_cmd_busy_n = cmd_busy; s_ws = ws;
        wlen = rw ? 0 : len;
        for (int i = 0; i < 256; i++) begin
            rx_mem[i] = 8'($urandom);
            wmem[i]   = 8'($urandom);
        end
        @(negedge clk); s_clr = 1;
        @(negedge clk);
        @(negedge clk); s_clr = 0;
    endtask

    task automatic issue(input bit rw, input logic [6:0] addr, input int len);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_rw = rw; req_addr = addr; req_len = len[7:0]; req_valid = 1;
        @(negedge clk);
        req_valid = 0; req_rw = 1'($urandom); req_addr = 7'($urandom); req_len = 8'($urandom);
    endtask

    task automatic run_txn(input string tag, input bit rw, input logic [6:0] addr, input int len,
                           input int busy_n, input int cmd_busy, input int ws);
        int n;
        setup_txn(rw, len, busy_n, cmd_busy, ws);
        build_exp(rw, addr, len, busy_n, cmd_busy);
        issue(rw, addr, len);
        for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_err"}, err_cnt, {31'd0, exp_err});
        chk({tag, "_log_len"}, log_q.size(), exp_log.size());
        n = (log_q.size() < exp_log.size()) ? log_q.size() : exp_log.size();
        for (int i = 0; i < n; i++) chk({tag, "_apb"}, {15'd0, log_q[i]}, {15'd0, exp_log[i]});
        chk({tag, "_wr_pulses"}, wr_pulses, exp_wr);
        chk({tag, "_rd_len"}, rd_q.size(), exp_rd.size());
        n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) chk({tag, "_rd_byte"}, {24'd0, rd_q[i]}, {24'd0, exp_rd[i]});
        chk({tag, "_protocol"}, prot, 0);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_rw = 0; req_addr = 0; req_len = 0;
        s_rw = 0; s_busy_n = 0; s_cmd_busy_n = 0; s_ws = 0; s_clr = 1; wlen = 0;
        repeat (3) @(negedge clk);
        rst = 0; s_clr = 0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", {24'd0, paddr}, 32'd0);
        chk("rst_pwdata", {24'd0, pwdata}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_wr_rd", {30'd0, wr_ready, rd_valid}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);

        // Directed write: 0x50, A5, 3C.
        setup_txn(0, 2, 0, 3, 0);
        wmem[0] = 8'hA5; wmem[1] = 8'h3C;
        build_exp(0, 7'h50, 2, 0, 3);
        issue(0, 7'h50, 2);
        for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("wr2_done", done_cnt, 1);
        chk("wr2_err", err_cnt, 0);
        chk("wr2_log_len", log_q.size(), exp_log.size());
        for (int i = 0; i < log_q.size() && i < exp_log.size(); i++)
            chk("wr2_apb", {15'd0, log_q[i]}, {15'd0, exp_log[i]});
        chk("wr2_wr_pulses", wr_pulses, 2);
        chk("wr2_protocol", prot, 0);

        // Directed read: 0x1D, RXEMPTY for 5 polls, bytes 11 22 33.
        setup_txn(1, 3, 5, 2, 0);
        rx_mem[0] = 8'h11; rx_mem[1] = 8'h22; rx_mem[2] = 8'h33;
        build_exp(1, 7'h1D, 3, 5, 2);
        issue(1, 7'h1D, 3);
        for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("rd3_done", done_cnt, 1);
        chk("rd3_log_len", log_q.size(), exp_log.size());
        for (int i = 0; i < log_q.size() && i < exp_log.size(); i++)
            chk("rd3_apb", {15'd0, log_q[i]}, {15'd0, exp_log[i]});
        chk("rd3_rd_len", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            chk("rd3_b0", {24'd0, rd_q[0]}, 32'h11);
            chk("rd3_b1", {24'd0, rd_q[1]}, 32'h22);
            chk("rd3_b2", {24'd0, rd_q[2]}, 32'h33);
        end

        run_txn("txfull", 0, 7'h2A, 1, 10, 1, 0);
        run_txn("cmd_timeout", 0, 7'h33, 0, 0, 1000, 0);
        run_txn("stat_timeout", 1, 7'h44, 2, TO, 0, 1);
        run_txn("waitst_len0", 0, 7'h12, 0, 0, 2, 3);
        run_txn("waitst_rd", 1, 7'h61, 2, 1, 1, 3);
        run_txn("len255", 1, 7'h7F, 255, 0, 0, 0);

        // Reset in the middle of a transfer.
        setup_txn(0, 3, 2, 2, 1);
        issue(0, 7'h05, 3);
        repeat (15) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_psel", {31'd0, psel}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_psel_idle", {31'd0, psel}, 32'd0);

        for (int t = 0; t < 12; t++)
            run_txn("rand", 1'($urandom), 7'($urandom), $urandom_range(0, 6),
                    $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_apb_seq_ctrl.md
Name: i2c_apb_seq_ctrl

Overview:
APB master sequencer that drives the I2C master register block (prescaler/cmd/transmit/receive/address_rw/status at 0x00–0x05) on behalf of a simple host request port. It runs one complete I2C transaction per request: it programs the registers, streams bytes through the transmit and receive FIFOs by polling status, then waits for the core to clear the cmd enable bit. It sits between system logic and the register block, on the same pclk domain.

Parameters:
PRESCALE, 8'h04, value written to prescaler (0x00) at the start of every transaction
CMD_GO, 8'h44, value written to cmd (0x01) to start a transfer; bit 6 = enable
STAT_TXFULL_BIT, 0, status (0x05) bit meaning transmit FIFO full
STAT_RXEMPTY_BIT, 1, status bit meaning receive FIFO empty
TIMEOUT, 16'd1000, maximum consecutive polls per wait before abort

Ports:
pclk_i  in  1  clock
preset_i  in  1  reset; synchronous, active-high
req_valid_i  in  1  transaction request
req_ready_o  out  1  high only in IDLE; request accepted when valid&ready
req_rw_i  in  1  0 = write to I2C slave, 1 = read
req_addr_i  in  7  I2C slave address
req_len_i  in  8  byte count; 0 = address-only transaction
wr_data_i  in  8  next byte to transmit
wr_valid_i  in  1  wr_data_i valid
wr_ready_o  out  1  one-cycle pulse when wr_data_i is consumed
rd_data_o  out  8  received byte
rd_valid_o  out  1  one-cycle pulse with rd_data_o
done_o  out  1  one-cycle pulse at end of transaction
err_o  out  1  one-cycle pulse with done_o on timeout
psel_o, penable_o, pwrite_o  out  1 each  APB controls
paddr_o  out  8  APB address
pwdata_o  out  8  APB write data
prdata_i  in  8  APB read data
pready_i  in  1  APB ready

Behaviour:
- Reset (synchronous, preset_i high at a pclk edge): all outputs 0 except req_ready_o = 1; state IDLE; counters 0. Reset mid-transfer aborts immediately with no done_o pulse; the APB bus drops psel_o the next cycle.
- APB transfer: SETUP cycle (psel=1, penable=0, addr/wdata/pwrite stable), then ACCESS (psel=1, penable=1), held until pready_i=1. prdata_i is sampled on the ACCESS cycle with pready_i=1. psel_o and penable_o return to 0 for at least one cycle between transfers. Minimum 3 cycles per transfer.
- Request accept: latch rw, addr, len and clear the byte counter.
- State sequence: IDLE -> W_PRE (write 0x00 = PRESCALE) -> W_ADDR (write 0x04 = {addr, rw}) -> W_CMD (write 0x01 = CMD_GO).
  - If len = 0 -> POLL_DONE.
  - If rw = 0 -> POLL_TX.
  - If rw = 1 -> POLL_RX.
- POLL_TX: read 0x05. If TXFULL=1, repeat. If TXFULL=0, wait in WAIT_WD for wr_valid_i, then pulse wr_ready_o and go to PUSH (write 0x02 = captured byte). After the push, increment the count: if count = len -> POLL_DONE, else -> POLL_TX.
- POLL_RX: read 0x05. If RXEMPTY=1, repeat. Otherwise go to POP (read 0x03), then pulse rd_valid_o with the sampled byte on the cycle after ACCESS completes. Increment the count: if count = len -> POLL_DONE, else -> POLL_RX.
- POLL_DONE: read 0x01 until bit 6 = 0 -> DONE.
- DONE: pulse done_o for 1 cycle, then IDLE.
- Timeout:
  - The poll counter increments per status/cmd read returning a "not yet" value and resets on progress.
  - When it reaches TIMEOUT: write 0x01 = 8'h00, pulse done_o and err_o together, return to IDLE.
  - WAIT_WD has no timeout; the host must supply data.
- Width rules: the byte count is 8 bits, compared for equality with len (len = 255 is legal). The poll counter is 16 bits, saturating.
- req_valid_i is ignored outside IDLE. wr_valid_i is ignored outside WAIT_WD.

Decomposition:
- Shared package i2c_pkg holds:
  - register address constants REG_PRESCALER..REG_STATUS (0x00–0x05)
  - CMD_EN_BIT = 6
  - status bit indices
  - the state enum
- Sub-module i2c_apb_xfer: single-transfer APB master engine. Interface: start, write, addr, wdata -> busy, done pulse, rdata. The top FSM issues one start per state.

Test Plan:
- Reset: hold preset_i for 2 cycles mid-transfer -> next cycle psel_o=0, req_ready_o=1, no done_o pulse.
- Write, len=2, addr 0x50, data A5,3C; slave model with status 0x02, cmd bit 6 clears after 20 cycles -> APB writes in order 00<-04, 04<-A0, 01<-44, 02<-A5, 02<-3C, then cmd reads, then a single done_o with err_o=0; exactly 2 wr_ready_o pulses.
- Read, len=3, addr 0x1D; RXEMPTY=1 for 5 polls, then FIFO bytes 11,22,33 -> 04<-3B, reads of 0x03 follow each RXEMPTY=0 poll, rd_valid_o bytes 11,22,33 in order, then done_o.
- TXFULL back-pressure: status 0x01 for 10 polls -> exactly 10 extra status reads; no transmit write until TXFULL=0.
- Timeout: TIMEOUT=8, cmd bit 6 stuck at 1 -> 8 cmd polls, then a write 01<-00 and done_o=err_o=1 in the same cycle; req_ready_o=1 the next cycle.
- Wait states and len=0: pready_i low for 3 cycles on each ACCESS -> penable_o held and prdata_i sampled only when pready_i=1. With len=0: PRE, ADDR, CMD, POLL_DONE, done_o, and no 0x02/0x03 accesses.
